// File: rtl/alu_issue_queue_if.sv
// Bundle for the ALU issue queue: flush, dispatch port, wakeup (writeback) bus,
// registered issue port and the occupancy count.
interface alu_issue_queue_if #(
  parameter int DEPTH = 4
);
  logic                       flush;
  logic                       disp_valid;
  logic                       disp_ready;
  logic [5:0]                 disp_Operation;
  logic [4:0]                 disp_Rdst;
  logic [5:0]                 disp_Phydst;
  logic [3:0]                 disp_Commit_Window;
  logic [31:0]                disp_imm;
  logic [31:0]                disp_Src1;
  logic [31:0]                disp_Src2;
  logic                       disp_Src1_rdy;
  logic                       disp_Src2_rdy;
  logic [5:0]                 disp_Src1_tag;
  logic [5:0]                 disp_Src2_tag;
  logic                       WB_valid;
  logic [5:0]                 WB_Phydst;
  logic [31:0]                WB_Result;
  logic                       EX_en;
  logic [5:0]                 EX_Operation;
  logic [4:0]                 EX_Rdst;
  logic [5:0]                 EX_Phydst;
  logic [3:0]                 EX_Commit_Window;
  logic [31:0]                EX_imm;
  logic [31:0]                EX_Src1;
  logic [31:0]                EX_Src2;
  logic [$clog2(DEPTH):0]     occupancy;

  modport master (
    output flush, disp_valid, disp_Operation, disp_Rdst, disp_Phydst, disp_Commit_Window,
           disp_imm, disp_Src1, disp_Src2, disp_Src1_rdy, disp_Src2_rdy, disp_Src1_tag,
           disp_Src2_tag, WB_valid, WB_Phydst, WB_Result,
    input  disp_ready, EX_en, EX_Operation, EX_Rdst, EX_Phydst, EX_Commit_Window, EX_imm,
           EX_Src1, EX_Src2, occupancy
  );

  modport slave (
    input  flush, disp_valid, disp_Operation, disp_Rdst, disp_Phydst, disp_Commit_Window,
           disp_imm, disp_Src1, disp_Src2, disp_Src1_rdy, disp_Src2_rdy, disp_Src1_tag,
           disp_Src2_tag, WB_valid, WB_Phydst, WB_Result,
    output disp_ready, EX_en, EX_Operation, EX_Rdst, EX_Phydst, EX_Commit_Window, EX_imm,
           EX_Src1, EX_Src2, occupancy
  );
endinterface

// File: rtl/alu_issue_queue.sv
// Age-ordered compacting ALU issue queue: oldest-ready-first select, writeback
// wakeup with dispatch bypass, one issue and one dispatch per cycle.
module alu_issue_queue #(
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  alu_issue_queue_if.slave  q
);
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rdst;
    logic [5:0]  phydst;
    logic [3:0]  cw;
    logic [31:0] imm;
    logic [31:0] src1;
    logic        src1_rdy;
    logic [5:0]  src1_tag;
    logic [31:0] src2;
    logic        src2_rdy;
    logic [5:0]  src2_tag;
  } entry_t;

  entry_t             ent_q [DEPTH];
  entry_t             ent_d [DEPTH];
  entry_t             new_e;
  entry_t             shifted;
  logic [OCC_W-1:0]   occ_q;
  logic [OCC_W-1:0]   occ_d;
  logic [OCC_W-1:0]   tail;
  logic [IDX_W-1:0]   sel;
  logic               issue_any;
  logic               accept;

  // Ready operands are left untouched; only waiting operands capture the broadcast.
  function automatic entry_t wake(input entry_t e, input logic wb_v,
                                  input logic [5:0] wb_tag, input logic [31:0] wb_res);
    entry_t r;
    r = e;
    if (wb_v && !r.src1_rdy && r.src1_tag == wb_tag) begin
      r.src1     = wb_res;
      r.src1_rdy = 1'b1;
    end
    if (wb_v && !r.src2_rdy && r.src2_tag == wb_tag) begin
      r.src2     = wb_res;
      r.src2_rdy = 1'b1;
    end
    return r;
  endfunction

  assign q.disp_ready = (occ_q < OCC_W'(DEPTH));
  assign q.occupancy  = occ_q;
  assign accept       = q.disp_valid && q.disp_ready && !q.flush;
  assign tail         = occ_q - OCC_W'(issue_any);

  always_comb begin
    issue_any = 1'b0;
    sel       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (OCC_W'(i) < occ_q && ent_q[i].src1_rdy && ent_q[i].src2_rdy) begin
        issue_any = 1'b1;
        sel       = IDX_W'(i);
      end
    end
  end

  always_comb begin
    new_e          = '0;
    new_e.op       = q.disp_Operation;
    new_e.rdst     = q.disp_Rdst;
    new_e.phydst   = q.disp_Phydst;
    new_e.cw       = q.disp_Commit_Window;
    new_e.imm      = q.disp_imm;
    new_e.src1     = q.disp_Src1;
    new_e.src1_rdy = q.disp_Src1_rdy;
    new_e.src1_tag = q.disp_Src1_tag;
    new_e.src2     = q.disp_Src2;
    new_e.src2_rdy = q.disp_Src2_rdy;
    new_e.src2_tag = q.disp_Src2_tag;
    new_e          = wake(new_e, q.WB_valid, q.WB_Phydst, q.WB_Result);
  end

  // Compact over the issued slot, wake every survivor, then append at the new tail.
  always_comb begin
    shifted = '0;
    for (int i = 0; i < DEPTH; i++) begin
      shifted = ent_q[i];
      if (issue_any && i >= int'(sel) && i < DEPTH - 1) shifted = ent_q[IDX_W'(i + 1)];
      ent_d[i] = wake(shifted, q.WB_valid, q.WB_Phydst, q.WB_Result);
      if (accept && OCC_W'(i) == tail) ent_d[i] = new_e;
    end
  end

  always_comb begin
    occ_d = occ_q + OCC_W'(accept) - OCC_W'(issue_any);
    if (q.flush) occ_d = '0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
  end

  // Issue stage boundary: registered hand-off to the ALU.
  always_ff @(posedge clk) begin
    if (!rst) begin
      occ_q              <= '0;
      q.EX_en            <= 1'b0;
      q.EX_Operation     <= '0;
      q.EX_Rdst          <= '0;
      q.EX_Phydst        <= '0;
      q.EX_Commit_Window <= '0;
      q.EX_imm           <= '0;
      q.EX_Src1          <= '0;
      q.EX_Src2          <= '0;
    end else begin
      occ_q   <= occ_d;
      q.EX_en <= issue_any && !q.flush;
      if (issue_any && !q.flush) begin
        q.EX_Operation     <= ent_q[sel].op;
        q.EX_Rdst          <= ent_q[sel].rdst;
        q.EX_Phydst        <= ent_q[sel].phydst;
        q.EX_Commit_Window <= ent_q[sel].cw;
        q.EX_imm           <= ent_q[sel].imm;
        q.EX_Src1          <= ent_q[sel].src1;
        q.EX_Src2          <= ent_q[sel].src2;
      end
    end
  end
endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of queue entries (power of two, 2..8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset.
REQ-004 flush  input  1  active-high; discards all queued and issuing work.
REQ-005 disp_valid  input  1  dispatch request.
REQ-006 disp_ready  output  1  queue can accept a dispatch this cycle.
REQ-007 disp_Operation/disp_Rdst/disp_Phydst/disp_Commit_Window/disp_imm  input  6/5/6/4/32  ALU op fields.
REQ-008 disp_Src1, disp_Src2  input  32 each  operand values, meaningful when matching rdy bit is 1.
REQ-009 disp_Src1_rdy, disp_Src2_rdy  input  1 each  operand already available.
REQ-010 disp_Src1_tag, disp_Src2_tag  input  6 each  producer physical register when not ready.
REQ-011 WB_valid, WB_Phydst, WB_Result  input  1/6/32  result broadcast (wakeup bus).
REQ-012 EX_en, EX_Operation, EX_Rdst, EX_Phydst, EX_Commit_Window, EX_imm, EX_Src1, EX_Src2  output  1/6/5/6/4/32/32/32  registered issue to ALU stage.
REQ-013 occupancy  output  $clog2(DEPTH)+1  valid entries count.

Function
REQ-014 Storage: age-ordered compacting array; slot 0 oldest; valid entries contiguous from slot 0.
REQ-015 disp_ready = (occupancy < DEPTH), combinational from state only; no same-cycle issue credit.
REQ-016 Dispatch accepted when disp_valid & disp_ready & ~flush; written at tail slot after any same-cycle issue compaction.
REQ-017 Dispatch with disp_valid & ~disp_ready: ignored, no state change.
REQ-018 Entry ready = both operands ready; selection = lowest-index ready entry (oldest-first).
REQ-019 Issue: if any entry ready, selected entry's fields registered onto EX_* with EX_en=1 next edge; entry removed, younger entries shift down one slot same edge.
REQ-020 No ready entry: EX_en=0 next edge; other EX_* hold previous values.
REQ-021 At most one issue and one dispatch per cycle; simultaneous both leaves occupancy unchanged.
REQ-022 Wakeup: for each valid non-ready operand with tag == WB_Phydst while WB_valid=1, capture WB_Result and set rdy at the edge; entry eligible for issue from the following cycle.
REQ-023 Dispatch bypass: operand dispatched with rdy=0 and tag == WB_Phydst while WB_valid=1 is stored ready with WB_Result.
REQ-024 Wakeup applies to entries shifting in the same cycle (captured value follows the entry to its new slot).
REQ-025 Ready operands never overwritten by wakeup.
REQ-026 Flush: all entries invalidated, occupancy=0, EX_en=0 at next edge; same-cycle dispatch dropped; flush overrides issue.
REQ-027 occupancy increments/decrements by at most 1 per cycle; never exceeds DEPTH nor wraps below 0.

Reset
REQ-028 rst=0 at a clock edge: all entries invalid, occupancy=0, EX_en=0, all other EX_* = 0; takes priority over flush, dispatch, wakeup.
REQ-029 disp_ready=1 from the first cycle after reset release.
REQ-030 Reset asserted mid-operation discards all entries with no partial issue.

Verification
REQ-031 Dispatch op with both rdy=1, Src1=5, Src2=7, Phydst=12 into empty queue -> next edge EX_en=1, EX_Src1=5, EX_Src2=7, EX_Phydst=12; occupancy returns to 0.
REQ-032 Dispatch A (Src1 tag 9, not ready) then B (both ready) -> B issues first; WB_valid=1, WB_Phydst=9, WB_Result=0x1234 -> A issues one cycle later with EX_Src1=0x1234.
REQ-033 Fill DEPTH=4 entries all non-ready -> disp_ready=0, fifth dispatch ignored; one wakeup freeing an entry -> disp_ready=1 the cycle after issue.
REQ-034 Dispatch with Src2 tag 3 same cycle as WB_Phydst=3, WB_Result=0xFF -> entry issues next cycle with EX_Src2=0xFF.
REQ-035 Three queued entries, flush=1 with disp_valid=1 -> next cycle occupancy=0, EX_en=0, no later issue of any flushed op.
REQ-036 rst=0 for one cycle with two ready entries queued -> EX_en=0, all EX_*=0, occupancy=0; no issue after release until new dispatch.
